// File: rtl/light_stick_pkg.sv
// Shared widths, constants, fetch FSM encoding and FIFO entry layout for the ROM fetch path.
package light_stick_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 6;

  localparam logic [ADDR_W-1:0] START_ADDR = 16'h0000;
  localparam logic [DATA_W-1:0] END_MARK   = 6'b111111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO; flush beats push/pop, simultaneous push+pop allowed when full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Program ROM reader: walks addresses, prefetches tagged words into a FIFO, stops at END_MARK.
module rom_fetch_unit
  import light_stick_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              restart,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               push;
  logic               pop;
  logic               flush;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [ENT_W-1:0]   head_raw;
  fetch_entry_t       head;
  fetch_entry_t       wr_entry;

  assign instr_valid = ~empty;
  assign pop         = instr_valid & instr_ready;
  assign wr_entry    = '{pc: rom_addr, word: rom_data};
  assign head        = fetch_entry_t'(head_raw);
  assign instr_pc    = head.pc;
  assign instr_data  = head.word;

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wr_entry),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head_raw)
  );

  // Restart outranks redirect; both flush and suppress the fetch that cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = rom_addr;
    push    = 1'b0;
    flush   = 1'b0;
    if (restart) begin
      flush   = 1'b1;
      addr_d  = START_ADDR;
      state_d = FETCH;
    end else if (redirect_valid) begin
      flush   = 1'b1;
      addr_d  = redirect_addr;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (rom_data == END_MARK) begin
            state_d = DRAIN;
          end else if (!full || pop) begin
            push   = 1'b1;
            addr_d = rom_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (count == '0) state_d = HALTED;
        end
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      rom_addr <= START_ADDR;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rom_addr <= addr_d;
      halted   <= (state_d == HALTED);
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: expected {pc,word} queued by stimulus, popped by a monitor.
module tb_rom_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rom_addr;
  logic [5:0]  rom_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0;
  logic        restart = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [5:0]  instr_data;
  logic [15:0] instr_pc;
  logic        halted;
  logic        zero_rom = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int delivered = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  rom_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .restart        (restart),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  // Program image: end marker at 0x008A, a few known words, filler elsewhere.
  function automatic logic [5:0] img(input logic [15:0] a);
    logic [5:0] t;
    if (a == 16'h008A) return 6'b111111;
    if (a == 16'h0002) return 6'b010100;
    if (a == 16'h0040) return 6'b100000;
    if (a == 16'h0089) return 6'b110110;
    t = 6'(a[5:0] * 6'd5 + 6'd1);
    if (t == 6'b111111) t = 6'b000000;
    return t;
  endfunction

  assign rom_data = zero_rom ? 6'b000000 : img(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_range(input logic [15:0] lo, input logic [15:0] hi);
    for (int a = int'(lo); a <= int'(hi); a++)
      exp_q.push_back({16'(a), img(16'(a))});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    delivered = 0;
    first_cyc = -1;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(halted), 32'h1);
    chk({name, "_qempty"}, 32'(exp_q.size()), 32'h0);
    chk({name, "_valid"}, 32'(instr_valid), 32'h0);
  endtask

  // Monitor: handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    logic [21:0] e;
    cyc++;
    if (rst_n && instr_valid) begin
      chk("no_endmark", 32'(instr_data == 6'b111111), 32'h0);
      if (instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pc", 32'(instr_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pc", 32'(instr_pc), 32'(e[21:6]));
          chk("data", 32'(instr_data), 32'(e[5:0]));
        end
        delivered++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: free-running stream to the end marker
    instr_ready = 1'b1;
    do_reset();
    push_range(16'h0000, 16'h0089);
    wait_halted("t1_halt");
    chk("t1_rate", 32'(last_cyc - first_cyc), 32'h89);
    chk("t1_addr_hold", 32'(rom_addr), 32'h8A);

    // 2: back-pressure from reset, then release
    instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("t2_lat_valid0", 32'(instr_valid), 32'h0);
    @(negedge clk);
    chk("t2_lat_valid1", 32'(instr_valid), 32'h1);
    chk("t2_lat_pc", 32'(instr_pc), 32'h0);
    repeat (8) @(negedge clk);
    chk("t2_stall_addr", 32'(rom_addr), 32'h4);
    chk("t2_head_pc", 32'(instr_pc), 32'h0);
    push_range(16'h0000, 16'h0089);
    first_cyc = -1;
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_halted("t2_halt");
    chk("t2_rate", 32'(last_cyc - first_cyc), 32'h89);

    // 3: redirect while FIFO holds pc 5..8
    instr_ready = 1'b1;
    do_reset();
    push_range(16'h0000, 16'h0089);
    n = 0;
    while (delivered < 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    instr_ready = 1'b0;
    chk("t3_delivered", 32'(delivered), 32'h5);
    repeat (8) @(posedge clk);
    #1;
    chk("t3_stall_addr", 32'(rom_addr), 32'h9);
    chk("t3_head_pc", 32'(instr_pc), 32'h5);
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0040;
    exp_q.delete();
    push_range(16'h0040, 16'h0089);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    chk("t3_redir_addr", 32'(rom_addr), 32'h40);
    chk("t3_flushed", 32'(instr_valid), 32'h0);
    wait_halted("t3_halt");

    // 4: restart from HALTED, then redirect+restart together
    push_range(16'h0000, 16'h0089);
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    chk("t4_unhalt", 32'(halted), 32'h0);
    chk("t4_addr", 32'(rom_addr), 32'h0);
    wait_halted("t4_halt");
    push_range(16'h0000, 16'h0089);
    @(posedge clk); #1;
    restart        = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0050;
    @(posedge clk); #1;
    restart        = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_both_addr", 32'(rom_addr), 32'h0);
    wait_halted("t4_both_halt");

    // 5: address wrap with an all-zero ROM
    instr_ready = 1'b0;
    zero_rom    = 1'b1;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_addr  = 16'hFFFE;
    exp_q.delete();
    exp_q.push_back({16'hFFFE, 6'h00});
    exp_q.push_back({16'hFFFF, 6'h00});
    exp_q.push_back({16'h0000, 6'h00});
    exp_q.push_back({16'h0001, 6'h00});
    delivered = 0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    n = 0;
    while (delivered < 4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    instr_ready = 1'b0;
    chk("t5_delivered", 32'(delivered), 32'h4);
    chk("t5_qempty", 32'(exp_q.size()), 32'h0);

    // 6: asynchronous reset with FIFO full
    zero_rom = 1'b0;
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    chk("t6_full_addr", 32'(rom_addr), 32'h4);
    chk("t6_full_valid", 32'(instr_valid), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(instr_valid), 32'h0);
    chk("t6_async_addr", 32'(rom_addr), 32'h0);
    chk("t6_async_pc", 32'(instr_pc), 32'h0);
    chk("t6_async_data", 32'(instr_data), 32'h0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    push_range(16'h0000, 16'h0089);
    wait_halted("t6_halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
